// File: rtl/uart_frame_assembler.sv
// Assembles UART bytes into 8-byte command frames (opcode/addr/data) behind a one-frame valid/ready buffer.
// Optional: define UART_FRAME_CHECKSUM_EN for 9-byte frames with a trailing XOR checksum and an o_csum_err pulse.
module uart_frame_assembler #(
  parameter int UART_HZ        = 50000000,
  parameter int BAUDRATE       = 115200,
  parameter int TIMEOUT_CYCLES = (UART_HZ / BAUDRATE) * 10 * 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  input  logic        i_frame_ready,
  output logic        o_frame_valid,
  output logic [15:0] o_opcode,
  output logic [15:0] o_addr,
  output logic [31:0] o_data,
  output logic        o_busy,
  output logic        o_timeout,
  output logic        o_overrun
`ifdef UART_FRAME_CHECKSUM_EN
  , output logic      o_csum_err
`endif
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t      state_r;
  logic [3:0]  count_r;
  logic [31:0] tmo_cnt_r;
  logic [63:0] asm_r;

  logic [63:0] asm_next_s;
  logic [63:0] frame_s;
  logic        frame_ok_s;
  logic        tmo_hit_s;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]  csum_r;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Next assembly value, frame candidate and timeout expiry detection
  always_comb begin
    asm_next_s = {asm_r[55:0], i_rx_data};
`ifdef UART_FRAME_CHECKSUM_EN
    // The checksum byte is compared, not shifted, so the frame is already in asm_r.
    frame_s    = asm_r;
    frame_ok_s = (csum_r == i_rx_data);
`else
    frame_s    = asm_next_s;
    frame_ok_s = 1'b1;
`endif
    tmo_hit_s  = TMO_EN && (state_r == COLLECT) && !i_rx_done &&
                 ((tmo_cnt_r + 32'd1) == TMO_LIMIT);
  end

  // Assembly FSM, timeout counter and output frame buffer
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r       <= IDLE;
      count_r       <= 4'd0;
      tmo_cnt_r     <= 32'd0;
      asm_r         <= 64'd0;
      o_frame_valid <= 1'b0;
      o_opcode      <= 16'd0;
      o_addr        <= 16'd0;
      o_data        <= 32'd0;
      o_busy        <= 1'b0;
      o_timeout     <= 1'b0;
      o_overrun     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_r        <= 8'd0;
      o_csum_err    <= 1'b0;
`endif
    end else begin
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      o_csum_err <= 1'b0;
`endif
      if (o_frame_valid && i_frame_ready) begin
        o_frame_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (i_rx_done) begin
            asm_r     <= asm_next_s;
            count_r   <= 4'd1;
            tmo_cnt_r <= 32'd0;
            o_busy    <= 1'b1;
            state_r   <= COLLECT;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_r    <= i_rx_data;
`endif
          end
        end
        COLLECT: begin
          if (i_rx_done) begin
            tmo_cnt_r <= 32'd0;
            if (count_r == LAST_IDX) begin
              count_r <= 4'd0;
              asm_r   <= 64'd0;
              o_busy  <= 1'b0;
              state_r <= IDLE;
              if (frame_ok_s) begin
                // A transfer in this same cycle frees the buffer for the new frame.
                if (!o_frame_valid || i_frame_ready) begin
                  o_frame_valid <= 1'b1;
                  o_opcode      <= frame_s[63:48];
                  o_addr        <= frame_s[47:32];
                  o_data        <= frame_s[31:0];
                end else begin
                  o_overrun <= 1'b1;
                end
              end else begin
`ifdef UART_FRAME_CHECKSUM_EN
                o_csum_err <= 1'b1;
`endif
              end
            end else begin
              asm_r   <= asm_next_s;
              count_r <= count_r + 4'd1;
`ifdef UART_FRAME_CHECKSUM_EN
              csum_r  <= csum_update(csum_r, i_rx_data);
`endif
            end
          end else if (tmo_hit_s) begin
            count_r   <= 4'd0;
            tmo_cnt_r <= 32'd0;
            asm_r     <= 64'd0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            state_r   <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          count_r   <= 4'd0;
          tmo_cnt_r <= 32'd0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed self-checking bench for uart_frame_assembler (TIMEOUT_CYCLES=100).
module tb_uart_frame_assembler;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        i_clock;
  logic        i_reset;
  logic        i_rx_done;
  logic [7:0]  i_rx_data;
  logic        i_frame_ready;
  logic        o_frame_valid;
  logic [15:0] o_opcode;
  logic [15:0] o_addr;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_timeout;
  logic        o_overrun;
`ifdef UART_FRAME_CHECKSUM_EN
  logic        o_csum_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  uart_frame_assembler #(
    .UART_HZ(50000000),
    .BAUDRATE(115200),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data),
    .i_frame_ready(i_frame_ready),
    .o_frame_valid(o_frame_valid),
    .o_opcode(o_opcode),
    .o_addr(o_addr),
    .o_data(o_data),
    .o_busy(o_busy),
    .o_timeout(o_timeout),
    .o_overrun(o_overrun)
`ifdef UART_FRAME_CHECKSUM_EN
    , .o_csum_err(o_csum_err)
`endif
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [7:0] frame_byte(input logic [63:0] f, input int i);
    logic [7:0] x;
    if (i < 8) return f[63 - 8*i -: 8];
    x = 8'd0;
    for (int k = 0; k < 8; k++) x = x ^ f[63 - 8*k -: 8];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
  endtask

  // Sends the first n wire bytes of frame f (checksum byte appended when enabled).
  task automatic send_part(input logic [63:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(frame_byte(f, i));
  endtask

  task automatic check_frame(input string tag, input logic [63:0] f);
    check({tag, "_valid"}, {63'd0, o_frame_valid}, 64'd1);
    check({tag, "_opcode"}, {48'd0, o_opcode}, {48'd0, f[63:48]});
    check({tag, "_addr"}, {48'd0, o_addr}, {48'd0, f[47:32]});
    check({tag, "_data"}, {32'd0, o_data}, {32'd0, f[31:0]});
  endtask

  initial begin
    i_reset = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_frame_ready = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;

    // Reset state
    check("rst_valid", {63'd0, o_frame_valid}, 64'd0);
    check("rst_opcode", {48'd0, o_opcode}, 64'd0);
    check("rst_addr", {48'd0, o_addr}, 64'd0);
    check("rst_data", {32'd0, o_data}, 64'd0);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_timeout", {63'd0, o_timeout}, 64'd0);
    check("rst_overrun", {63'd0, o_overrun}, 64'd0);

    // Basic frame with ready high
    i_frame_ready = 1'b1;
    send_part(64'h0123456789ABCDEF, 1);
    check("basic_busy", {63'd0, o_busy}, 64'd1);
    for (int i = 1; i < NB; i++) send_byte(frame_byte(64'h0123456789ABCDEF, i));
    check_frame("basic", 64'h0123456789ABCDEF);
    check("basic_busy_end", {63'd0, o_busy}, 64'd0);
    tick();
    check("basic_drop", {63'd0, o_frame_valid}, 64'd0);

    // Overrun: hold first frame, second completes while stalled
    i_frame_ready = 1'b0;
    send_part(64'h1122334455667788, NB);
    check_frame("hold1", 64'h1122334455667788);
    send_part(64'hA1A2A3A4A5A6A7A8, NB);
    check("ovr_pulse", {63'd0, o_overrun}, 64'd1);
    check_frame("hold2", 64'h1122334455667788);
    tick();
    check("ovr_clear", {63'd0, o_overrun}, 64'd0);
    check_frame("hold3", 64'h1122334455667788);
    i_frame_ready = 1'b1;
    tick();
    check("ovr_xfer", {63'd0, o_frame_valid}, 64'd0);
    i_frame_ready = 1'b0;

    // Timeout after 3 bytes, then a clean frame
    send_part(64'h0102030405060708, 3);
    for (int i = 0; i < 99; i++) tick();
    check("tmo_busy99", {63'd0, o_busy}, 64'd1);
    check("tmo_pulse99", {63'd0, o_timeout}, 64'd0);
    tick();
    check("tmo_pulse", {63'd0, o_timeout}, 64'd1);
    check("tmo_busy", {63'd0, o_busy}, 64'd0);
    tick();
    check("tmo_clear", {63'd0, o_timeout}, 64'd0);
    i_frame_ready = 1'b1;
    send_part(64'hDEADBEEF12345678, NB);
    check_frame("tmo_next", 64'hDEADBEEF12345678);
    tick();
    check("tmo_next_drop", {63'd0, o_frame_valid}, 64'd0);

    // Ready rises in the cycle the next frame completes
    i_frame_ready = 1'b0;
    send_part(64'h0102030405060708, NB);
    check_frame("swap_hold", 64'h0102030405060708);
    send_part(64'hF0F1F2F3F4F5F6F7, NB - 1);
    i_frame_ready = 1'b1;
    send_byte(frame_byte(64'hF0F1F2F3F4F5F6F7, NB - 1));
    check_frame("swap_new", 64'hF0F1F2F3F4F5F6F7);
    check("swap_no_ovr", {63'd0, o_overrun}, 64'd0);
    tick();
    check("swap_drop", {63'd0, o_frame_valid}, 64'd0);

    // Reset with a held frame and a partial frame in flight
    i_frame_ready = 1'b0;
    send_part(64'hCAFEF00D0BADBEEF, NB);
    send_part(64'h5555555555555555, 5);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mrst_valid", {63'd0, o_frame_valid}, 64'd0);
    check("mrst_opcode", {48'd0, o_opcode}, 64'd0);
    check("mrst_data", {32'd0, o_data}, 64'd0);
    check("mrst_busy", {63'd0, o_busy}, 64'd0);
    i_frame_ready = 1'b1;
    send_part(64'h0123456789ABCDEF, NB);
    check_frame("mrst_next", 64'h0123456789ABCDEF);
    tick();

`ifdef UART_FRAME_CHECKSUM_EN
    // Checksum good and bad
    send_part(64'h0102030405060708, 8);
    send_byte(8'h08);
    check_frame("csum_good", 64'h0102030405060708);
    check("csum_good_err", {63'd0, o_csum_err}, 64'd0);
    tick();
    send_part(64'h0102030405060708, 8);
    send_byte(8'h00);
    check("csum_bad_err", {63'd0, o_csum_err}, 64'd1);
    check("csum_bad_valid", {63'd0, o_frame_valid}, 64'd0);
    check("csum_bad_ovr", {63'd0, o_overrun}, 64'd0);
    tick();
    check("csum_err_clear", {63'd0, o_csum_err}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
